axi4_dma_wr: RTL and testbench

- AXI4 master that drains a 64-bit word stream into a memory-mapped slave, typically axi4_sram, through the system interconnect.
- Used by the boot/loader path and peripherals to fill SRAM without CPU stores.
- Splits one software-programmed transfer into INCR bursts that never cross a 4 KB boundary.

---
 rtl/axi4_dma_wr_pkg.sv | 58 +++++
 rtl/types_amba_pkg.sv | 64 ++++++
 rtl/axi4_dma_wr.sv | 145 ++++++++++++++
 tb/tb_axi4_dma_wr.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_dma_wr_pkg.sv
// Types and helpers for axi4_dma_wr: FSM state enum, registered-state struct
// with its reset constant, 4 KB page mask, AXI size code and burst sizing.
package axi4_dma_wr_pkg;

    import types_amba_pkg::*;

    localparam int unsigned REM_BITS  = 32;
    localparam int unsigned BEAT_BITS = 9;

    localparam logic [11:0] PAGE_MASK   = 12'hFFF;
    localparam logic [2:0]  AXI_SIZE_8B = 3'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AW   = 3'd1,
        W    = 3'd2,
        B    = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef struct packed {
        state_t                          state;
        logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
        logic [REM_BITS-1:0]             remaining;
        logic [BEAT_BITS-1:0]            beats;
        logic [BEAT_BITS-1:0]            beat;
        logic                            err;
    } regs_t;

    localparam regs_t REGS_RESET = '{
        state:     IDLE,
        addr:      '0,
        remaining: '0,
        beats:     '0,
        beat:      '0,
        err:       1'b0
    };

    // Beats for the next burst: limited by words left, burst_max and the 4 KB page end
    function automatic logic [BEAT_BITS-1:0] calc_beats(
        input logic [REM_BITS-1:0] remaining,
        input logic [11:0]         addr_lo,
        input int unsigned         burst_max
    );
        logic [REM_BITS-1:0] page_words;
        logic [REM_BITS-1:0] n;
        page_words = (REM_BITS'(4096) - REM_BITS'(addr_lo & PAGE_MASK)) >> 3;
        n = remaining;
        if (n > REM_BITS'(burst_max)) begin
            n = REM_BITS'(burst_max);
        end
        if (n > page_words) begin
            n = page_words;
        end
        return BEAT_BITS'(n);
    endfunction

endpackage

// File: rtl/types_amba_pkg.sv
// System bus configuration and AXI4 master channel bundles shared by bus masters.
// Provides CFG_SYSBUS_* widths, the AXI burst/response encodings and the
// axi4_master_out_type / axi4_master_in_type packed structs.
package types_amba_pkg;

    localparam int unsigned CFG_SYSBUS_ADDR_BITS  = 32;
    localparam int unsigned CFG_SYSBUS_DATA_BITS  = 64;
    localparam int unsigned CFG_SYSBUS_DATA_BYTES = 8;
    localparam int unsigned CFG_SYSBUS_ID_BITS    = 5;
    localparam int unsigned CFG_SYSBUS_USER_BITS  = 1;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Address-channel payload shared by AW and AR
    typedef struct packed {
        logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
        logic [7:0]                      len;
        logic [2:0]                      size;
        logic [1:0]                      burst;
        logic                            lock;
        logic [3:0]                      cache;
        logic [2:0]                      prot;
        logic [3:0]                      qos;
        logic [3:0]                      region;
    } axi4_metadata_type;

    typedef struct packed {
        logic                             aw_valid;
        axi4_metadata_type                aw_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]    aw_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  aw_user;
        logic                             w_valid;
        logic [CFG_SYSBUS_DATA_BITS-1:0]  w_data;
        logic                             w_last;
        logic [CFG_SYSBUS_DATA_BYTES-1:0] w_strb;
        logic [CFG_SYSBUS_USER_BITS-1:0]  w_user;
        logic                             b_ready;
        logic                             ar_valid;
        axi4_metadata_type                ar_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]    ar_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  ar_user;
        logic                             r_ready;
    } axi4_master_out_type;

    typedef struct packed {
        logic                             aw_ready;
        logic                             w_ready;
        logic                             b_valid;
        logic [1:0]                       b_resp;
        logic [CFG_SYSBUS_ID_BITS-1:0]    b_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  b_user;
        logic                             ar_ready;
        logic                             r_valid;
        logic [1:0]                       r_resp;
        logic [CFG_SYSBUS_DATA_BITS-1:0]  r_data;
        logic                             r_last;
        logic [CFG_SYSBUS_ID_BITS-1:0]    r_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  r_user;
    } axi4_master_in_type;

endpackage

// File: rtl/axi4_dma_wr.sv
// AXI4 write-only DMA master: drains a 64-bit stream into memory as INCR
// bursts of up to burst_max beats that never cross a 4 KB page.
// Ports:
//   clk, nrst                      clock, async active-low reset
//   i_start/i_base_addr/i_len      transfer request (sampled in IDLE only)
//   i_data_valid/i_data            stream input; o_data_ready = accepted this cycle
//   o_busy/o_done/o_err            status: busy, one-cycle done pulse, sticky error
//   o_xmsto/i_xmsti                AXI4 master channels (read channel idle)
// Optional: AXI4_DMA_WR_ABORT_ON_ERR_EN ends the transfer on the first error response.
module axi4_dma_wr
    import types_amba_pkg::*;
    import axi4_dma_wr_pkg::*;
#(
    parameter int unsigned burst_max = 16,
    parameter int unsigned len_bits  = 16
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            i_start,
    input  logic [CFG_SYSBUS_ADDR_BITS-1:0] i_base_addr,
    input  logic [len_bits-1:0]             i_len,
    input  logic                            i_data_valid,
    input  logic [63:0]                     i_data,
    output logic                            o_data_ready,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_err,
    output axi4_master_out_type             o_xmsto,
    input  axi4_master_in_type              i_xmsti
);

    regs_t r;
    regs_t rin;

    logic [CFG_SYSBUS_ADDR_BITS-1:0] aligned_addr;
    logic [CFG_SYSBUS_ADDR_BITS-1:0] next_addr;
    logic [REM_BITS-1:0]             next_rem;
    logic                            last_beat;
    logic                            unused_inputs;

    // Response id/user and the whole read channel carry nothing for a write-only master
    assign unused_inputs = &{1'b0, i_xmsti.b_resp[0], i_xmsti.b_id, i_xmsti.b_user,
                             i_xmsti.ar_ready, i_xmsti.r_valid, i_xmsti.r_resp,
                             i_xmsti.r_data, i_xmsti.r_last, i_xmsti.r_id,
                             i_xmsti.r_user, i_base_addr[2:0]};

    assign aligned_addr = {i_base_addr[CFG_SYSBUS_ADDR_BITS-1:3], 3'b000};
    assign next_addr    = r.addr + (CFG_SYSBUS_ADDR_BITS'(r.beats) << 3);
    assign next_rem     = r.remaining - REM_BITS'(r.beats);
    assign last_beat    = (r.beat == (r.beats - BEAT_BITS'(1)));

    // Next-state and channel outputs
    always_comb begin
        rin          = r;
        o_xmsto      = '0;
        o_xmsto.r_ready = 1'b1;
        o_data_ready = 1'b0;
        o_busy       = (r.state != IDLE);
        o_done       = (r.state == DONE);
        o_err        = r.err;

        case (r.state)
            IDLE: begin
                if (i_start) begin
                    rin.addr      = aligned_addr;
                    rin.remaining = REM_BITS'(i_len);
                    rin.err       = 1'b0;
                    rin.beat      = '0;
                    if (i_len == '0) begin
                        rin.state = DONE;
                    end else begin
                        rin.beats = calc_beats(REM_BITS'(i_len), aligned_addr[11:0], burst_max);
                        rin.state = AW;
                    end
                end
            end

            AW: begin
                o_xmsto.aw_valid      = 1'b1;
                o_xmsto.aw_bits.addr  = r.addr;
                o_xmsto.aw_bits.len   = 8'(r.beats - BEAT_BITS'(1));
                o_xmsto.aw_bits.size  = AXI_SIZE_8B;
                o_xmsto.aw_bits.burst = AXI_BURST_INCR;
                if (i_xmsti.aw_ready) begin
                    rin.beat  = '0;
                    rin.state = W;
                end
            end

            W: begin
                o_xmsto.w_valid = i_data_valid;
                o_xmsto.w_data  = i_data;
                o_xmsto.w_strb  = 8'hFF;
                o_xmsto.w_last  = last_beat;
                o_data_ready    = i_xmsti.w_ready;
                if (i_data_valid && i_xmsti.w_ready) begin
                    rin.beat = r.beat + BEAT_BITS'(1);
                    if (last_beat) begin
                        rin.state = B;
                    end
                end
            end

            B: begin
                o_xmsto.b_ready = 1'b1;
                if (i_xmsti.b_valid) begin
                    if (i_xmsti.b_resp[1]) begin
                        rin.err = 1'b1;
                    end
                    rin.addr      = next_addr;
                    rin.remaining = next_rem;
                    if (next_rem == '0) begin
                        rin.state = DONE;
                    end else begin
                        rin.beats = calc_beats(next_rem, next_addr[11:0], burst_max);
                        rin.state = AW;
                    end
`ifdef AXI4_DMA_WR_ABORT_ON_ERR_EN
                    if (i_xmsti.b_resp[1]) begin
                        rin.state = DONE;
                    end
`endif
                end
            end

            DONE: begin
                rin.state = IDLE;
            end

            default: begin
                rin.state = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r <= REGS_RESET;
        end else begin
            r <= rin;
        end
    end

endmodule

// File: tb/tb_axi4_dma_wr.sv
// Randomized self-checking bench for axi4_dma_wr with a behavioural AXI slave,
// a stream source and a burst-split reference model.
`timescale 1ns/1ps
module tb_axi4_dma_wr;
    import types_amba_pkg::*;

    localparam int unsigned BURST_MAX = 16;
    localparam int unsigned LEN_BITS  = 16;

    logic                            clk = 1'b0;
    logic                            nrst = 1'b0;
    logic                            i_start = 1'b0;
    logic [CFG_SYSBUS_ADDR_BITS-1:0] i_base_addr = '0;
    logic [LEN_BITS-1:0]             i_len = '0;
    logic                            i_data_valid = 1'b0;
    logic [63:0]                     i_data = '0;
    logic                            o_data_ready;
    logic                            o_busy;
    logic                            o_done;
    logic                            o_err;
    axi4_master_out_type             xmsto;
    axi4_master_in_type              xmsti = '0;

    axi4_dma_wr #(.burst_max(BURST_MAX), .len_bits(LEN_BITS)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_len        (i_len),
        .i_data_valid (i_data_valid),
        .i_data       (i_data),
        .o_data_ready (o_data_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_xmsto      (xmsto),
        .i_xmsti      (xmsti)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          beats;
    } burst_t;

    int n_tests = 0;
    int n_fail  = 0;

    int aw_pct = 100;
    int w_pct  = 100;
    int b_pct  = 100;
    int v_pct  = 100;
    int err_burst = -1;

    burst_t      exp_aw[$];
    int          open_beats[$];
    logic [31:0] open_addr[$];
    logic [1:0]  b_q[$];
    logic [63:0] stream[$];
    logic [63:0] mem[int unsigned];
    int stream_idx = 0;
    int aw_seen = 0;
    int w_beat = 0;
    int w_burst = 0;
    int cyc = 0;
    int last_b_cyc = -10;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    // Slave and stream source: drive at negedge, evaluate handshakes 1 ns later
    initial begin : slave
        logic        aw_pend;
        logic [31:0] aw_pend_addr;
        burst_t      e;
        aw_pend = 1'b0;
        aw_pend_addr = '0;
        forever begin
            @(negedge clk);
            cyc++;
            xmsti = '0;
            xmsti.aw_ready = pct(aw_pct);
            xmsti.w_ready  = (open_beats.size() > 0) && pct(w_pct);
            if (b_q.size() > 0 && pct(b_pct)) begin
                xmsti.b_valid = 1'b1;
                xmsti.b_resp  = b_q[0];
            end
            i_data_valid = (stream_idx < stream.size()) && pct(v_pct);
            i_data = (stream_idx < stream.size()) ? stream[stream_idx] : {$urandom, $urandom};
            #1;
            if (!nrst) begin
                aw_pend = 1'b0;
            end else begin
                if (aw_pend) begin
                    check("aw_valid_hold", 64'(xmsto.aw_valid), 64'(1));
                    check("aw_addr_hold", 64'(xmsto.aw_bits.addr), 64'(aw_pend_addr));
                end
                aw_pend = xmsto.aw_valid && !xmsti.aw_ready;
                aw_pend_addr = xmsto.aw_bits.addr;
                if (xmsto.aw_valid && xmsti.aw_ready) begin
                    aw_seen++;
                    check("aw_expected", 64'(exp_aw.size() > 0), 64'(1));
                    if (exp_aw.size() > 0) begin
                        e = exp_aw.pop_front();
                        check("aw_addr", 64'(xmsto.aw_bits.addr), 64'(e.addr));
                        check("aw_len", 64'(xmsto.aw_bits.len), 64'(e.beats - 1));
                        check("aw_size", 64'(xmsto.aw_bits.size), 64'(3));
                        check("aw_burst", 64'(xmsto.aw_bits.burst), 64'(1));
                        check("aw_attr", 64'({xmsto.aw_id, xmsto.aw_user, xmsto.aw_bits.lock,
                              xmsto.aw_bits.cache, xmsto.aw_bits.prot, xmsto.aw_bits.qos,
                              xmsto.aw_bits.region}), 64'(0));
                        open_beats.push_back(e.beats);
                        open_addr.push_back(e.addr);
                    end
                end
                if (o_data_ready) begin
                    check("ready_without_wready", 64'(xmsti.w_ready), 64'(1));
                end
                if (xmsto.w_valid && xmsti.w_ready && open_beats.size() > 0) begin
                    check("w_last", 64'(xmsto.w_last), 64'(w_beat == open_beats[0] - 1));
                    check("w_strb", 64'(xmsto.w_strb), 64'(8'hFF));
                    mem[(open_addr[0] >> 3) + 32'(w_beat)] = xmsto.w_data;
                    w_beat++;
                    if (w_beat == open_beats[0]) begin
                        void'(open_beats.pop_front());
                        void'(open_addr.pop_front());
                        b_q.push_back((w_burst == err_burst) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
                        w_burst++;
                        w_beat = 0;
                    end
                end
                if (i_data_valid && o_data_ready) begin
                    stream_idx++;
                end
                if (xmsti.b_valid && xmsto.b_ready) begin
                    void'(b_q.pop_front());
                    last_b_cyc = cyc;
                end
            end
        end
    end

    task automatic clear_model();
        mem.delete();
        stream.delete();
        exp_aw.delete();
        open_beats.delete();
        open_addr.delete();
        b_q.delete();
        stream_idx = 0;
        aw_seen = 0;
        w_beat = 0;
        w_burst = 0;
        last_b_cyc = -10;
    endtask

    // One transfer: build the expected burst list, run it, then check results
    task automatic run_xfer(input logic [31:0] base, input int len, input int err_b, input bit poke);
        logic [31:0] a;
        int rem, bt, page, n_bursts, exp_words, start_cyc, done_cyc;
        bit seen, aborted, poked, exp_err;
        clear_model();
        err_burst = err_b;
        for (int k = 0; k < len; k++) begin
            stream.push_back({$urandom, $urandom});
        end
        a = base & ~32'h7;
        rem = len;
        n_bursts = 0;
        exp_words = 0;
        aborted = 1'b0;
        while (rem > 0 && !aborted) begin
            page = (4096 - int'(a % 4096)) / 8;
            bt = rem;
            if (bt > int'(BURST_MAX)) bt = int'(BURST_MAX);
            if (bt > page) bt = page;
            exp_aw.push_back('{addr: a, beats: bt});
            a += 32'(8 * bt);
            rem -= bt;
            exp_words += bt;
`ifdef AXI4_DMA_WR_ABORT_ON_ERR_EN
            if (n_bursts == err_b) aborted = 1'b1;
`endif
            n_bursts++;
        end
        exp_err = (err_b >= 0) && (err_b < n_bursts);

        @(negedge clk); #3;
        i_start = 1'b1;
        i_base_addr = base;
        i_len = LEN_BITS'(len);
        start_cyc = cyc;
        @(negedge clk); #3;
        i_start = 1'b0;
        check("err_cleared_on_start", 64'(o_err), 64'(0));
        check("busy_after_start", 64'(o_busy), 64'(1));

        seen = 1'b0;
        poked = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            i_start = 1'b0;
            if (o_done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end else begin
                if (poke && !poked && stream_idx >= 2 && stream_idx < len - 1) begin
                    i_start = 1'b1;
                    i_base_addr = 32'h0000_8000;
                    i_len = LEN_BITS'(5);
                    poked = 1'b1;
                end
                @(negedge clk); #3;
            end
        end
        i_start = 1'b0;
        check("done_seen", 64'(seen), 64'(1));
        if (!seen) begin
            nrst = 1'b0;
            repeat (2) @(negedge clk);
            clear_model();
            nrst = 1'b1;
        end else begin
            if (len == 0) begin
                check("done_latency_zero_len", 64'(done_cyc), 64'(start_cyc + 1));
            end else begin
                check("done_after_b", 64'(done_cyc), 64'(last_b_cyc + 1));
            end
            check("err_at_done", 64'(o_err), 64'(exp_err));
            check("aw_count", 64'(aw_seen), 64'(n_bursts));
            check("words_consumed", 64'(stream_idx), 64'(exp_words));
            for (int k = 0; k < exp_words; k++) begin
                if (mem.exists(((base & ~32'h7) >> 3) + 32'(k))) begin
                    check("mem_data", mem[((base & ~32'h7) >> 3) + 32'(k)], stream[k]);
                end else begin
                    check("mem_written", 64'(0), 64'(1));
                end
            end
            @(negedge clk); #3;
            check("done_one_cycle", 64'(o_done), 64'(0));
            check("idle_after_done", 64'(o_busy), 64'(0));
            check("err_sticky", 64'(o_err), 64'(exp_err));
        end
    endtask

    initial begin : main
        int len;
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_done", 64'(o_done), 64'(0));
        check("rst_err", 64'(o_err), 64'(0));
        check("rst_aw_valid", 64'(xmsto.aw_valid), 64'(0));
        check("rst_w_valid", 64'(xmsto.w_valid), 64'(0));
        check("rst_b_ready", 64'(xmsto.b_ready), 64'(0));
        check("rst_ar_valid", 64'(xmsto.ar_valid), 64'(0));
        check("rst_r_ready", 64'(xmsto.r_ready), 64'(1));
        check("rst_data_ready", 64'(o_data_ready), 64'(0));
        @(negedge clk);
        nrst = 1'b1;

        run_xfer(32'h0000_1000, 4, -1, 1'b0);
        run_xfer(32'h0000_0000, 40, -1, 1'b0);
        run_xfer(32'h0000_0FF0, 4, -1, 1'b0);
        run_xfer(32'h0000_1FF8, 3, -1, 1'b0);
        run_xfer(32'h0000_2003, 5, -1, 1'b0);
        run_xfer(32'h0000_3000, 0, -1, 1'b0);

        aw_pct = 50; w_pct = 50; b_pct = 50; v_pct = 50;
        run_xfer(32'h0000_4F80, 20, -1, 1'b0);
        run_xfer(32'h0000_5000, 12, -1, 1'b1);

        aw_pct = 100; w_pct = 100; b_pct = 100; v_pct = 100;
        run_xfer(32'h0000_0000, 20, 0, 1'b0);
        run_xfer(32'h0000_6000, 3, -1, 1'b0);

        for (int t = 0; t < 8; t++) begin
            aw_pct = int'($urandom_range(40, 100));
            w_pct  = int'($urandom_range(40, 100));
            b_pct  = int'($urandom_range(40, 100));
            v_pct  = int'($urandom_range(40, 100));
            len = int'($urandom_range(1, 50));
            run_xfer(32'($urandom_range(0, 4095)) << 3, len,
                     ($urandom_range(3) == 0) ? int'($urandom_range(0, 2)) : -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
